// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory-stage SRAM controller.
package arm_pkg;

    // SRAM data bus width (one half-word per SRAM access)
    localparam int unsigned SRAM_DW          = 16;
    // Default controller parameters
    localparam int unsigned WAIT_CYCLES_DEF  = 5;
    localparam int unsigned SRAM_AW_DEF      = 18;
    localparam int unsigned MEM_BASE_DEF     = 1024;

    // Access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_LO = 3'd1,
        ST_WR_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_RD_HI = 3'd4,
        ST_DONE  = 3'd5
    } mem_state_e;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM-stage controller: splits 32-bit loads/stores into two
// 16-bit SRAM phases, each WAIT_CYCLES long; ready low stalls the pipeline.
module sram_mem_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
    parameter int unsigned MEM_BASE    = MEM_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        eff;
    logic [SRAM_AW-2:0] word;
    logic               cnt_last;
    logic               unused_eff_bits;

    // Byte address to SRAM 32-bit word index; byte offset and upper bits are ignored
    always_comb begin
        eff             = addr_q - 32'(MEM_BASE);
        word            = eff[SRAM_AW:2];
        unused_eff_bits = ^{eff[31:SRAM_AW+1], eff[1:0]};
        cnt_last        = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
    end

    // State, phase counter and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, SRAM strobes and read-data capture
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                ready = ~(rd_en | wr_en);
                if (wr_en) begin
                    addr_d  = address;
                    wdata_d = wdata;
                    state_d = ST_WR_LO;
                end else if (rd_en) begin
                    addr_d  = address;
                    state_d = ST_RD_LO;
                end
            end
            ST_WR_LO: begin
                sram_addr  = {word, 1'b0};
                sram_dq_oe = 1'b1;
                sram_dq_o  = wdata_q[15:0];
                // Strobe released on the last cycle to give data hold time
                sram_we_n  = cnt_last;
                if (cnt_last) state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                sram_addr  = {word, 1'b1};
                sram_dq_oe = 1'b1;
                sram_dq_o  = wdata_q[31:16];
                sram_we_n  = cnt_last;
                if (cnt_last) state_d = ST_DONE;
            end
            ST_RD_LO: begin
                sram_addr = {word, 1'b0};
                sram_oe_n = 1'b0;
                if (cnt_last) begin
                    rdata_d[15:0] = sram_dq_i;
                    state_d       = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                sram_addr = {word, 1'b1};
                sram_oe_n = 1'b0;
                if (cnt_last) begin
                    rdata_d[31:16] = sram_dq_i;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Phase counter restarts on every state change and idles at zero
        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl with a behavioural 256K x 16 SRAM.
module tb_sram_mem_ctrl;

    localparam int unsigned AW      = 18;
    localparam int          TIMEOUT = 60;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, wdata, rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_i, sram_dq_o;
    logic          sram_dq_oe, sram_we_n, sram_oe_n;

    logic [15:0]   mem    [0:(1<<AW)-1];
    logic [15:0]   shadow [0:63];
    logic [31:0]   last_rd;

    typedef struct {
        int          lat;
        int          we_low;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    sram_mem_ctrl #(.WAIT_CYCLES(5), .SRAM_AW(AW), .MEM_BASE(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write while strobe is low
    assign sram_dq_i = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one access at cycle 0 (called just after a rising edge), wait for ready
    task automatic do_access(input string tag, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] wd, input bit drop);
        exp_t e;
        int   stall = 0;
        int   wel   = 0;
        bit   done  = 0;
        int   w;
        w = int'((addr - 32'd1024) >> 2);
        e.lat    = 11;
        e.we_low = wr ? 8 : 0;
        if (wr) begin
            shadow[2*w]   = wd[15:0];
            shadow[2*w+1] = wd[31:16];
            e.rdata       = last_rd;
        end else begin
            e.rdata = {shadow[2*w+1], shadow[2*w]};
            last_rd = e.rdata;
        end
        sb_q.push_back(e);
        wr_en   = wr;
        rd_en   = rd;
        address = addr;
        wdata   = wd;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                break;
            end
            stall++;
            if (!sram_we_n) wel++;
        end
        e = sb_q.pop_front();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'(e.lat));
        chk({tag, "_we_low"}, 32'(wel), 32'(e.we_low));
        chk({tag, "_rdata"}, rdata, e.rdata);
        @(posedge clk);
        #1;
        if (drop) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 16'h0;
            shadow[i] = 16'h0;
        end
        mem[2] = 16'h2222; mem[3] = 16'h1111;
        mem[4] = 16'h4444; mem[5] = 16'h3333;
        shadow[2] = 16'h2222; shadow[3] = 16'h1111;
        shadow[4] = 16'h4444; shadow[5] = 16'h3333;
        last_rd = 32'h0;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;

        // Reset held three cycles, then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;

        // Store, then read back
        do_access("st1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1);
        chk("st1024_mem0", 32'(mem[0]), 32'(shadow[0]));
        chk("st1024_mem1", 32'(mem[1]), 32'(shadow[1]));
        do_access("ld1024", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ld1024_hold", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Back-to-back loads with the request held across DONE
        do_access("ld1028", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        do_access("ld1032", 1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);

        // Simultaneous read and write: write wins, rdata untouched
        do_access("both1036", 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 1'b1);
        chk("both_mem6", 32'(mem[6]), 32'(shadow[6]));
        chk("both_mem7", 32'(mem[7]), 32'(shadow[7]));

        // Reset during the low phase of a store aborts it
        wr_en = 1'b1; address = 32'd1024; wdata = 32'h12345678;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_mem1", 32'(mem[1]), 32'hDEAD);
        @(posedge clk); #1;

        // Controller recovers after the abort
        last_rd = 32'h0;
        do_access("ld1028_post", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
